// File: rtl/reaction_stats_if.sv
// Tester-to-statistics bundle: stop/run/status/count from the tester, results back to display logic.
// HISTORY_EN adds the history select/readout pair.
interface reaction_stats_if;
    logic        stop_test;
    logic        run;
    logic        test_active;
    logic [15:0] count;
    logic [15:0] last_time;
    logic [15:0] best_time;
    logic        best_valid;
    logic [7:0]  trials;
    logic [7:0]  false_starts;
    logic        result_valid;
    logic        new_best;
    logic        false_start;
`ifdef HISTORY_EN
    logic [1:0]  hist_sel;
    logic [15:0] hist_time;

    modport master (
        output stop_test, run, test_active, count, hist_sel,
        input  last_time, best_time, best_valid, trials, false_starts,
               result_valid, new_best, false_start, hist_time
    );
    modport slave (
        input  stop_test, run, test_active, count, hist_sel,
        output last_time, best_time, best_valid, trials, false_starts,
               result_valid, new_best, false_start, hist_time
    );
`else
    modport master (
        output stop_test, run, test_active, count,
        input  last_time, best_time, best_valid, trials, false_starts,
               result_valid, new_best, false_start
    );
    modport slave (
        input  stop_test, run, test_active, count,
        output last_time, best_time, best_valid, trials, false_starts,
               result_valid, new_best, false_start
    );
`endif
endinterface

// File: rtl/reaction_stats.sv
// Reaction-tester statistics: classifies each stop press as valid/false-start/ignored and keeps
// last, best, trial and false-start counts. Optional 4-deep history of valid times under HISTORY_EN.
module reaction_stats (
    input  logic             CLOCK_50,
    input  logic             reset,
    reaction_stats_if.slave  bus
);

    logic        r_stop_q;
    logic [15:0] r_last_time;
    logic [15:0] r_best_time;
    logic        r_best_valid;
    logic [7:0]  r_trials;
    logic [7:0]  r_false_starts;
    logic        r_result_valid;
    logic        r_new_best;
    logic        r_false_start;

    logic w_stop_edge;
    logic w_valid;
    logic w_false;
    logic w_better;

    // Two-digit BCD increment that sticks at 99 instead of wrapping.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] res;
        res = v;
        if (v != 8'h99) begin
            if (v[3:0] == 4'd9) res = {v[7:4] + 4'd1, 4'd0};
            else                res = {v[7:4], v[3:0] + 4'd1};
        end
        return res;
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        w_stop_edge = bus.stop_test & ~r_stop_q;
        w_valid     = w_stop_edge & bus.test_active;
        w_false     = w_stop_edge & ~bus.test_active & bus.run;
        // Packed BCD orders the same as plain unsigned binary, so a direct compare is exact.
        w_better    = w_valid & (~r_best_valid | (bus.count < r_best_time));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_stop_q       <= 1'b0;
            r_last_time    <= 16'h0000;
            r_best_time    <= 16'h0000;
            r_best_valid   <= 1'b0;
            r_trials       <= 8'h00;
            r_false_starts <= 8'h00;
            r_result_valid <= 1'b0;
            r_new_best     <= 1'b0;
            r_false_start  <= 1'b0;
        end else begin
            r_stop_q       <= bus.stop_test;
            r_result_valid <= w_valid;
            r_new_best     <= w_better;
            r_false_start  <= w_false;
            if (w_valid) begin
                r_last_time <= bus.count;
                r_trials    <= bcd_inc(r_trials);
            end
            if (w_better) begin
                r_best_time  <= bus.count;
                r_best_valid <= 1'b1;
            end
            if (w_false) begin
                r_false_starts <= bcd_inc(r_false_starts);
            end
        end
    end

    assign bus.last_time    = r_last_time;
    assign bus.best_time    = r_best_time;
    assign bus.best_valid   = r_best_valid;
    assign bus.trials       = r_trials;
    assign bus.false_starts = r_false_starts;
    assign bus.result_valid = r_result_valid;
    assign bus.new_best     = r_new_best;
    assign bus.false_start  = r_false_start;

`ifdef HISTORY_EN
    logic [15:0] r_hist [4];

    // NOTE: the history array is reset like ordinary flops; it is tiny and must read zero after reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) r_hist[k] <= 16'h0000;
        end else if (w_valid) begin
            r_hist[0] <= bus.count;
            for (int k = 1; k < 4; k++) r_hist[k] <= r_hist[k-1];
        end
    end

    assign bus.hist_time = r_hist[bus.hist_sel];
`endif

endmodule

// File: tb/tb_reaction_stats.sv
// Self-checking bench for reaction_stats: directed scenarios plus randomized stop/run/status traffic
// checked every cycle against a list-based model of valid results and false starts.
module tb_reaction_stats;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    reaction_stats_if bus ();

    reaction_stats dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Model: the full list of accepted times and a false-start tally; outputs derived from them.
    logic        m_prev_stop = 1'b0;
    logic [15:0] m_times [$];
    int          m_n_false = 0;
    logic        e_rv = 1'b0, e_nb = 1'b0, e_fs = 1'b0;

    function automatic logic [7:0] to_bcd2(input int n);
        int s;
        s = (n > 99) ? 99 : n;
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] m_min();
        logic [15:0] m;
        m = 16'hFFFF;
        foreach (m_times[i]) if (m_times[i] < m) m = m_times[i];
        return m;
    endfunction

    function automatic logic [15:0] m_hist(input int k);
        return (m_times.size() > k) ? m_times[m_times.size() - 1 - k] : 16'h0000;
    endfunction

    task automatic check_all();
        int n;
        n = m_times.size();
        check("last_time",    bus.last_time,    (n > 0) ? m_times[n-1] : 16'h0000);
        check("best_time",    bus.best_time,    (n > 0) ? m_min() : 16'h0000);
        check("best_valid",   bus.best_valid,   n > 0);
        check("trials",       bus.trials,       to_bcd2(n));
        check("false_starts", bus.false_starts, to_bcd2(m_n_false));
        check("result_valid", bus.result_valid, e_rv);
        check("new_best",     bus.new_best,     e_nb);
        check("false_start",  bus.false_start,  e_fs);
`ifdef HISTORY_EN
        check("hist_time",    bus.hist_time,    m_hist(int'(bus.hist_sel)));
`endif
    endtask

    // One clock: drive at negedge, update model, clock, then compare shortly after the edge.
    task automatic step(input logic s, input logic r, input logic ta, input logic [15:0] c,
                        input logic rst = 1'b0);
        logic edge_seen;
        @(negedge CLOCK_50);
        bus.stop_test   = s;
        bus.run         = r;
        bus.test_active = ta;
        bus.count       = c;
        reset           = rst;
`ifdef HISTORY_EN
        bus.hist_sel    = 2'($urandom_range(0, 3));
`endif
        if (rst) begin
            m_prev_stop = 1'b0;
            m_times.delete();
            m_n_false = 0;
            e_rv = 1'b0; e_nb = 1'b0; e_fs = 1'b0;
        end else begin
            edge_seen   = s && !m_prev_stop;
            m_prev_stop = s;
            e_rv = edge_seen && ta;
            e_nb = e_rv && (m_times.size() == 0 || c < m_min());
            e_fs = edge_seen && !ta && r;
            if (e_rv) m_times.push_back(c);
            if (e_fs) m_n_false++;
        end
        @(posedge CLOCK_50);
        #2;
        check_all();
    endtask

    // A press of the given kind followed by a release cycle.
    task automatic press(input logic r, input logic ta, input logic [15:0] c);
        step(1'b1, r, ta, c);
        step(1'b0, 1'b0, 1'b0, c);
    endtask

    function automatic logic [15:0] rand_bcd();
        if ($urandom_range(0, 15) == 0) return 16'h9999;
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

`ifdef HISTORY_EN
    task automatic hist_readout();
        for (int k = 0; k < 4; k++) begin
            bus.hist_sel = 2'(k);
            #1;
            check("hist_read", bus.hist_time, m_hist(k));
        end
    endtask
`endif

    initial begin
        bus.stop_test   = 1'b0;
        bus.run         = 1'b0;
        bus.test_active = 1'b0;
        bus.count       = 16'h0000;
`ifdef HISTORY_EN
        bus.hist_sel    = 2'd0;
`endif
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0000);

        // First valid result, then a slower one, then a new best.
        press(1'b0, 1'b1, 16'h0234);
        press(1'b0, 1'b1, 16'h0456);
        press(1'b0, 1'b1, 16'h0199);
        press(1'b0, 1'b1, 16'h0199);
        // False start, then an ignored press.
        press(1'b1, 1'b0, 16'h0000);
        press(1'b0, 1'b0, 16'h0777);
        // Held stop produces exactly one event even with test_active held high.
        step(1'b1, 1'b0, 1'b1, 16'h0300);
        repeat (49) step(1'b1, 1'b0, 1'b1, 16'h0050);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        // Saturated tester value and counter saturation at 99.
        press(1'b0, 1'b1, 16'h9999);
        repeat (100) press(1'b0, 1'b1, rand_bcd());
        repeat (100) press(1'b1, 1'b0, rand_bcd());
        // Reset concurrent with a valid edge, then stop still held out of reset.
        step(1'b1, 1'b0, 1'b1, 16'h0111, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0111);
        step(1'b0, 1'b0, 1'b0, 16'h0000);

        // History ordering; the false start in the middle must not shift it.
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        press(1'b0, 1'b1, 16'h0100);
        press(1'b0, 1'b1, 16'h0200);
        press(1'b0, 1'b1, 16'h0300);
        press(1'b1, 1'b0, 16'h0000);
        press(1'b0, 1'b1, 16'h0400);
        press(1'b0, 1'b1, 16'h0500);
`ifdef HISTORY_EN
        hist_readout();
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom), rand_bcd(),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
